// File: rtl/fetch_stage_pkg.sv
// Shared RV32 pipeline definitions: fetch defaults, XLEN and the fetch FSM encoding.
// Imported by the fetch stage, the decoder and the hazard unit.
package fetch_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0100_0000;
    localparam logic [XLEN-1:0] NOP_INSN_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_skid_reg.sv
// Skid register for the fetch stage: catches the memory word on the first stall cycle
// and presents it until the stall resolves.
module fetch_stage_skid_reg
    import fetch_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            capture,
    input  logic            clear,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] insn
);

    logic            hold_valid;
    logic [XLEN-1:0] hold_insn;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid <= 1'b0;
        end else if (clear) begin
            hold_valid <= 1'b0;
        end else if (capture) begin
            hold_valid <= 1'b1;
        end
    end

    // Data word carries no reset; hold_valid qualifies it.
    always_ff @(posedge clk) begin
        if (capture) begin
            hold_insn <= rdata;
        end
    end

    assign insn = hold_valid ? hold_insn : rdata;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction memory and
// presents pc/insn pairs to decode, absorbing stalls and honouring EX redirects.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INSN = NOP_INSN_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_en,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_insn,
    output logic            out_misaligned
);

    fetch_state_e    state, state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight_valid;
    logic            inflight_mis;
    logic            redir;
    logic            issue;
    logic [XLEN-1:0] issue_pc;
    logic            issue_mis;
    logic            capture;
    logic            clear;
    logic [XLEN-1:0] skid_insn;

    assign redir = redirect_valid && (state != BOOT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_d;
        end
    end

    // Redirect outranks stall in every state but BOOT.
    always_comb begin
        state_d   = state;
        issue     = 1'b0;
        capture   = 1'b0;
        clear     = 1'b0;
        imem_addr = pc_q;
        issue_pc  = pc_q;
        issue_mis = 1'b0;
        if (redir) begin
            issue     = 1'b1;
            clear     = 1'b1;
            imem_addr = word_align(redirect_pc);
            issue_pc  = redirect_pc;
            issue_mis = |redirect_pc[1:0];
            state_d   = RUN;
        end else begin
            case (state)
                BOOT: begin
                    issue     = 1'b1;
                    imem_addr = RESET_PC;
                    issue_pc  = RESET_PC;
                    state_d   = RUN;
                end
                RUN: begin
                    if (!stall) begin
                        issue = 1'b1;
                    end else if (inflight_valid) begin
                        capture = 1'b1;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        issue   = 1'b1;
                        clear   = 1'b1;
                        state_d = RUN;
                    end
                end
                default: state_d = BOOT;
            endcase
        end
    end

    assign imem_en = issue & ~reset;

    // Issue boundary: a new request replaces the in-flight one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q           <= RESET_PC;
            inflight_valid <= 1'b0;
            inflight_mis   <= 1'b0;
        end else if (issue) begin
            pc_q           <= imem_addr + 32'd4;
            inflight_valid <= 1'b1;
            inflight_mis   <= issue_mis;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            inflight_pc <= issue_pc;
        end
    end

    fetch_stage_skid_reg u_skid (
        .clk     (clk),
        .reset   (reset),
        .capture (capture),
        .clear   (clear),
        .rdata   (imem_rdata),
        .insn    (skid_insn)
    );

    assign out_valid      = inflight_valid;
    assign out_pc         = inflight_pc;
    assign out_misaligned = inflight_mis;
    assign out_insn       = inflight_mis ? NOP_INSN : skid_insn;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: cycle table from reset release plus hand sequences
// for reset mid-stall and redirect during BOOT.
module tb_fetch_stage;

    localparam logic [31:0] B   = 32'h0100_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] BAD = 32'hBAD0_BAD0;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_insn;
    logic        out_misaligned;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        en;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] insn;
        logic        mis;
    } vec_t;

    vec_t vecs[24];
    int   nv = 0;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_en        (imem_en),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_insn       (out_insn),
        .out_misaligned (out_misaligned)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Synchronous memory; an unread cycle leaves garbage so only the skid can hold data.
    always @(posedge clk) begin
        imem_rdata <= imem_en ? word(imem_addr) : BAD;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic rv, input logic [31:0] rpc,
                       input logic en, input logic [31:0] addr, input logic v,
                       input logic [31:0] pc, input logic [31:0] insn, input logic mis);
        vecs[nv] = '{s, rv, rpc, en, addr, v, pc, insn, mis};
        nv++;
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;

        //  stall rv  rpc            en   addr           v    pc             insn                 mis
        add(1'b0, 1'b0, 32'h0,       1'b1, B,            1'b0, 32'h0,        32'h0,               1'b0);
        add(1'b0, 1'b0, 32'h0,       1'b1, B+32'h4,      1'b1, B,            word(B),             1'b0);
        add(1'b0, 1'b0, 32'h0,       1'b1, B+32'h8,      1'b1, B+32'h4,      word(B+32'h4),       1'b0);
        add(1'b1, 1'b0, 32'h0,       1'b0, B+32'hC,      1'b1, B+32'h8,      word(B+32'h8),       1'b0);
        add(1'b1, 1'b0, 32'h0,       1'b0, B+32'hC,      1'b1, B+32'h8,      word(B+32'h8),       1'b0);
        add(1'b1, 1'b0, 32'h0,       1'b0, B+32'hC,      1'b1, B+32'h8,      word(B+32'h8),       1'b0);
        add(1'b0, 1'b0, 32'h0,       1'b1, B+32'hC,      1'b1, B+32'h8,      word(B+32'h8),       1'b0);
        add(1'b0, 1'b1, B+32'h100,   1'b1, B+32'h100,    1'b1, B+32'hC,      word(B+32'hC),       1'b0);
        add(1'b0, 1'b0, 32'h0,       1'b1, B+32'h104,    1'b1, B+32'h100,    word(B+32'h100),     1'b0);
        add(1'b1, 1'b0, 32'h0,       1'b0, B+32'h108,    1'b1, B+32'h104,    word(B+32'h104),     1'b0);
        add(1'b1, 1'b1, B+32'h200,   1'b1, B+32'h200,    1'b1, B+32'h104,    word(B+32'h104),     1'b0);
        add(1'b0, 1'b0, 32'h0,       1'b1, B+32'h204,    1'b1, B+32'h200,    word(B+32'h200),     1'b0);
        add(1'b0, 1'b1, B+32'h102,   1'b1, B+32'h100,    1'b1, B+32'h204,    word(B+32'h204),     1'b0);
        add(1'b0, 1'b0, 32'h0,       1'b1, B+32'h104,    1'b1, B+32'h102,    NOP,                 1'b1);
        add(1'b0, 1'b0, 32'h0,       1'b1, B+32'h108,    1'b1, B+32'h104,    word(B+32'h104),     1'b0);
        add(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b1, B+32'h108, word(B+32'h108),     1'b0);
        add(1'b0, 1'b0, 32'h0,       1'b1, 32'h0,        1'b1, 32'hFFFF_FFFC, word(32'hFFFF_FFFC), 1'b0);
        add(1'b0, 1'b0, 32'h0,       1'b1, 32'h4,        1'b1, 32'h0,        word(32'h0),         1'b0);
        add(1'b1, 1'b1, B+32'h300,   1'b1, B+32'h300,    1'b1, 32'h4,        word(32'h4),         1'b0);
        add(1'b0, 1'b0, 32'h0,       1'b1, B+32'h304,    1'b1, B+32'h300,    word(B+32'h300),     1'b0);

        repeat (2) @(negedge clk);
        #1;
        check("rst_en",    {31'h0, imem_en},        32'h0);
        check("rst_valid", {31'h0, out_valid},      32'h0);
        check("rst_mis",   {31'h0, out_misaligned}, 32'h0);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < nv; i++) begin
            stall = vecs[i].stall;
            redirect_valid = vecs[i].rv;
            redirect_pc = vecs[i].rpc;
            #1;
            check($sformatf("v%0d_en", i),    {31'h0, imem_en},   {31'h0, vecs[i].en});
            if (vecs[i].en)
                check($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
            check($sformatf("v%0d_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].valid});
            if (vecs[i].valid) begin
                check($sformatf("v%0d_pc", i),   out_pc,   vecs[i].pc);
                check($sformatf("v%0d_insn", i), out_insn, vecs[i].insn);
                check($sformatf("v%0d_mis", i),  {31'h0, out_misaligned}, {31'h0, vecs[i].mis});
            end
            @(negedge clk);
        end

        // Stall, then reset asserted in the middle of the second stall cycle.
        stall = 1'b1;
        redirect_valid = 1'b0;
        #1;
        check("st1_en",   {31'h0, imem_en}, 32'h0);
        check("st1_pc",   out_pc,   B+32'h304);
        check("st1_insn", out_insn, word(B+32'h304));
        @(negedge clk);
        #1;
        check("st2_pc",   out_pc,   B+32'h304);
        check("st2_insn", out_insn, word(B+32'h304));
        reset = 1'b1;
        #1;
        check("mrst_valid", {31'h0, out_valid},      32'h0);
        check("mrst_en",    {31'h0, imem_en},        32'h0);
        check("mrst_mis",   {31'h0, out_misaligned}, 32'h0);
        @(negedge clk);
        @(negedge clk);

        // Release into BOOT with a redirect that must be ignored.
        reset = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0200_0000;
        #1;
        check("boot_en",    {31'h0, imem_en},   32'h1);
        check("boot_addr",  imem_addr,          B);
        check("boot_valid", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("rb1_valid", {31'h0, out_valid}, 32'h1);
        check("rb1_pc",    out_pc,    B);
        check("rb1_insn",  out_insn,  word(B));
        check("rb1_addr",  imem_addr, B+32'h4);
        @(negedge clk);
        #1;
        check("rb2_pc",   out_pc,   B+32'h4);
        check("rb2_insn", out_insn, word(B+32'h4));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
